// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one valid/ready bus transaction per access,
// stalls the pipeline until the response and returns the aligned, extended load value.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_ena,
    input  logic        mem_w_ena,
    input  logic [7:0]  byte_enable,
    input  logic        mem_ext_un,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        rdata_valid,
    output logic [63:0] rdata,
    output logic        err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_wen,
    output logic [63:0] bus_req_addr,
    output logic [7:0]  bus_req_wstrb,
    output logic [63:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [63:0] bus_resp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    state_t        state, state_next;
    logic [CW-1:0] tcount;
    logic          wen_q, ext_q;
    logic [7:0]    size_q;
    logic [2:0]    off_q;

    logic          request, size_ok, aligned, legal, timeout_hit;
    logic          accept, illegal, abort;
    logic [63:0]   raw, load_ext;

    assign bus_req_valid = (state == REQ);
    assign bus_req_wen   = wen_q;
    assign done          = (state == DONE);
    assign rdata_valid   = (state == DONE) && !wen_q;

    // Legality of the request presented in IDLE: valid size mask and natural alignment.
    always_comb begin
        size_ok = 1'b1;
        aligned = 1'b1;
        case (byte_enable)
            8'h01:   aligned = 1'b1;
            8'h03:   aligned = ~addr[0];
            8'h0F:   aligned = (addr[1:0] == 2'b00);
            8'hFF:   aligned = (addr[2:0] == 3'b000);
            default: begin
                size_ok = 1'b0;
                aligned = 1'b0;
            end
        endcase
        request     = mem_r_ena | mem_w_ena;
        legal       = !(mem_r_ena && mem_w_ena) && size_ok && aligned;
        timeout_hit = (TIMEOUT != 0) && (tcount == TLAST);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Bus events take priority over the timeout on the cycle the counter expires.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept     = 1'b0;
        illegal    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (legal) begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        state_next = REQ;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_req_ready) begin
                    state_next = RESP;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            RESP: begin
                stall = 1'b1;
                if (bus_resp_valid) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        raw = bus_resp_rdata >> {off_q, 3'b000};
        case (size_q)
            8'h01:   load_ext = {{56{~ext_q & raw[7]}},  raw[7:0]};
            8'h03:   load_ext = {{48{~ext_q & raw[15]}}, raw[15:0]};
            8'h0F:   load_ext = {{32{~ext_q & raw[31]}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    // Request fields are captured once on acceptance so they stay stable through REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q         <= 1'b0;
            ext_q         <= 1'b0;
            size_q        <= 8'h00;
            off_q         <= 3'b000;
            bus_req_addr  <= 64'h0;
            bus_req_wstrb <= 8'h00;
            bus_req_wdata <= 64'h0;
            rdata         <= 64'h0;
            tcount        <= '0;
            err           <= 1'b0;
        end else begin
            err <= illegal | abort;
            if (accept) begin
                wen_q         <= mem_w_ena;
                ext_q         <= mem_ext_un;
                size_q        <= byte_enable;
                off_q         <= addr[2:0];
                bus_req_addr  <= {addr[63:3], 3'b000};
                bus_req_wstrb <= mem_w_ena ? (byte_enable << addr[2:0]) : 8'h00;
                bus_req_wdata <= wdata << {addr[2:0], 3'b000};
                tcount        <= '0;
            end else if (state == REQ || state == RESP) begin
                tcount <= tcount + CW'(1);
            end
            if (state == RESP && bus_resp_valid && !wen_q) begin
                rdata <= load_ext;
            end
        end
    end

endmodule
